// File: rtl/hub_cmd_initiator.sv
// Hub-side initiator for the logic-capture peripheral: drives regIn/command, waits for ack, captures regOut.
// Define LCHUB_TIMEOUT_EN to bound the wait states by TIMEOUT_CYCLES and report aborts on resp_timeout.
module hub_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [7:0]  resp_status,
  output logic        resp_timeout,
  output logic [7:0]  regIn0,
  output logic [7:0]  regIn1,
  output logic [7:0]  regIn2,
  output logic [7:0]  regIn3,
  output logic [7:0]  regIn4,
  output logic [7:0]  regIn5,
  output logic [7:0]  regIn6,
  output logic [7:0]  regIn7,
  input  logic [7:0]  regOut0,
  input  logic [7:0]  regOut1,
  input  logic [7:0]  regOut2,
  input  logic [7:0]  regOut3,
  input  logic [7:0]  regOut4,
  input  logic [7:0]  regOut5,
  input  logic [7:0]  regOut6,
  input  logic [7:0]  regOut7,
  output logic [7:0]  command,
  output logic        command_strobe,
  input  logic [7:0]  status,
  output logic        busy
);

  localparam logic [7:0] CMD_NOP = 8'h00;
  localparam logic [7:0] CMD_ACK = 8'h08;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE, PRECLR, WAIT_PRE, DRIVE, WAIT_ACK, CLEAR, WAIT_CLR, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] reg_in_q, reg_in_d;
  logic [7:0]  command_q, command_d;
  logic        strobe_q, strobe_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        busy_q, busy_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic [7:0]  resp_status_q, resp_status_d;
  logic        ack;
  logic        accept;
  logic        tmo_fire;

  assign ack    = status[3];
  assign accept = (state_q == IDLE) && req_valid && req_ready_q;

`ifdef LCHUB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             in_wait;
  logic             tmo_hit;
  logic             resp_timeout_q;

  // A normal wait-state exit on the limit cycle wins over the abort.
  assign in_wait   = (state_q == WAIT_PRE) || (state_q == WAIT_ACK) || (state_q == WAIT_CLR);
  assign tmo_hit   = in_wait && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign tmo_fire  = tmo_hit && ((state_q == WAIT_ACK) ? !ack : ack);
  assign tmo_cnt_d = (in_wait && (state_d == state_q)) ? tmo_cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q      <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (accept) begin
        resp_timeout_q <= 1'b0;
      end else if (tmo_fire) begin
        resp_timeout_q <= 1'b1;
      end
    end
  end

  assign resp_timeout = resp_timeout_q;
`else
  assign tmo_fire     = 1'b0;
  assign resp_timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    wdata_d       = wdata_q;
    resp_rdata_d  = resp_rdata_q;
    resp_status_d = resp_status_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d         = req_cmd;
          wdata_d       = req_wdata;
          resp_rdata_d  = '0;
          resp_status_d = '0;
          state_d       = ack ? PRECLR : DRIVE;
        end
      end
      PRECLR: state_d = WAIT_PRE;
      WAIT_PRE: begin
        if (!ack) begin
          state_d = DRIVE;
        end else if (tmo_fire) begin
          resp_status_d = status;
          state_d       = RESP;
        end
      end
      DRIVE: state_d = ((cmd_q == CMD_NOP) || (cmd_q == CMD_ACK)) ? RESP : WAIT_ACK;
      WAIT_ACK: begin
        if (ack) begin
          resp_rdata_d  = {regOut7, regOut6, regOut5, regOut4, regOut3, regOut2, regOut1, regOut0};
          resp_status_d = status;
          state_d       = CLEAR;
        end else if (tmo_fire) begin
          resp_rdata_d  = '0;
          resp_status_d = status;
          state_d       = RESP;
        end
      end
      CLEAR: state_d = WAIT_CLR;
      WAIT_CLR: begin
        if (!ack || tmo_fire) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every peripheral-facing signal is a flop.
    strobe_d     = (state_d == PRECLR) || (state_d == DRIVE) || (state_d == CLEAR);
    command_d    = CMD_NOP;
    reg_in_d     = reg_in_q;
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    busy_d       = (state_d != IDLE);
    if (state_d == DRIVE) begin
      command_d = cmd_d;
      reg_in_d  = wdata_d;
    end else if ((state_d == PRECLR) || (state_d == CLEAR)) begin
      command_d = CMD_ACK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      wdata_q       <= '0;
      reg_in_q      <= '0;
      command_q     <= '0;
      strobe_q      <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      resp_rdata_q  <= '0;
      resp_status_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      wdata_q       <= wdata_d;
      reg_in_q      <= reg_in_d;
      command_q     <= command_d;
      strobe_q      <= strobe_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      busy_q        <= busy_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_status    = resp_status_q;
  assign command        = command_q;
  assign command_strobe = strobe_q;
  assign busy           = busy_q;
  assign regIn0         = reg_in_q[7:0];
  assign regIn1         = reg_in_q[15:8];
  assign regIn2         = reg_in_q[23:16];
  assign regIn3         = reg_in_q[31:24];
  assign regIn4         = reg_in_q[39:32];
  assign regIn5         = reg_in_q[47:40];
  assign regIn6         = reg_in_q[55:48];
  assign regIn7         = reg_in_q[63:56];

endmodule

// File: doc/hub_cmd_initiator.md
# hub_cmd_initiator

- Hub-side initiator for the logic-capture peripheral's command/register interface.
- Accepts one host request at a time: a command byte plus a 64-bit write payload.
- Drives the eight input registers and a one-cycle command strobe, then waits for the peripheral's acknowledge status bit.
- Captures the eight output registers, clears the acknowledge with command 0x08, and returns the captured data and status to the host over a valid/ready response channel.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1024: wait-state cycle limit; used only when the timeout feature is compiled in.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE.
- req_cmd  in  8  command byte (0x00–0x0C).
- req_wdata  in  64  payload; byte i drives regIn<i>.
- resp_valid  out  1  response valid.
- resp_ready  in  1  host accepts the response.
- resp_rdata  out  64  captured {regOut7..regOut0}.
- resp_status  out  8  status snapshot taken at capture.
- resp_timeout  out  1  transaction aborted by timeout.
- regIn0..regIn7  out  8 each  peripheral input registers.
- regOut0..regOut7  in  8 each  peripheral output registers.
- command  out  8  command to the peripheral.
- command_strobe  out  1  one-cycle command qualifier.
- status  in  8  peripheral status; bit 3 = ack.
- busy  out  1  state != IDLE.

## Operation
States: IDLE, PRECLR, WAIT_PRE, DRIVE, WAIT_ACK, CLEAR, WAIT_CLR, RESP.

- **IDLE:** on req_valid && req_ready, latch req_cmd and req_wdata. Next state is PRECLR if status[3]=1 (stale ack), else DRIVE.
- **PRECLR:** command=0x08, command_strobe=1 for one cycle, then go to WAIT_PRE.
- **WAIT_PRE:** wait for status[3]=0, then go to DRIVE.
- **DRIVE:** regIn<i> = latched byte i; command = latched cmd; command_strobe=1 for one cycle.
  - If cmd is 0x00 (NOP) or 0x08 (ACK), no acknowledge is expected: go to RESP with resp_rdata=0.
  - Otherwise go to WAIT_ACK.
- **WAIT_ACK:** on the first cycle with status[3]=1, register regOut0..7 into resp_rdata and status into resp_status, then go to CLEAR.
- **CLEAR:** command=0x08, command_strobe=1 for one cycle, then go to WAIT_CLR.
- **WAIT_CLR:** wait for status[3]=0, then go to RESP.
- **RESP:** resp_valid=1. resp_rdata, resp_status and resp_timeout are held stable until resp_ready; then return to IDLE.

Register and command rules:
- regIn0..7 hold the latched payload from DRIVE until RESP exits. They are unchanged during PRECLR/CLEAR strobes.
- command returns to 0x00 whenever command_strobe=0.
- status is sampled directly. It is never double-registered.

## Timing
Reset values:
- IDLE, req_ready=1.
- resp_valid=0, resp_rdata=0, resp_status=0, resp_timeout=0.
- regIn0..7=0x00, command=0x00, command_strobe=0, busy=0.

Latency and ordering:
- All outputs are registered.
- Accept edge A → strobe in cycle A+1 (no pre-clear).
- The peripheral raises ack no earlier than strobe+2. Data is captured on that same edge.
- CLEAR strobe follows the capture by one cycle. Ack drops no earlier than clear strobe+2.
- Minimum accept→resp_valid latency: 7 cycles for acked commands, 2 cycles for 0x00/0x08.
- command_strobe is never high on two consecutive cycles.
- A request arriving while busy is not accepted; req_ready stays 0.
- resp_valid with resp_ready high in the same cycle: the response completes and req_ready=1 the next cycle.

Reset mid-transaction:
- Asynchronous return to reset values.
- No clear command is issued.
- Any pending ack is handled by the next request's PRECLR.

## Configuration
Macro LCHUB_TIMEOUT_EN.

When defined:
- A cycle counter runs in WAIT_PRE, WAIT_ACK and WAIT_CLR and reloads on each state entry.
- When it reaches TIMEOUT_CYCLES, the block goes to RESP with resp_timeout=1.
- On a WAIT_ACK timeout, resp_rdata=0 and resp_status holds the current status.
- Wait-state exits that occur on the same cycle as the limit take the normal path; ack wins.

When undefined:
- The counter logic is absent.
- Wait states are unbounded.
- resp_timeout is tied to 0.

## Test plan
1. **Config buffer:** req_cmd=0x04, req_wdata=0x0000_000A_0000_0064, peripheral acks at strobe+2.
   - Expect one 0x04 strobe, regIn0=0x64, regIn4=0x0A.
   - Expect one 0x08 strobe.
   - Expect resp_status[3]=1 and resp_valid 7 cycles after accept.
2. **Read trace size:** req_cmd=0x06, regOut3..0=0x0000_0190 at ack.
   - Expect resp_rdata[31:0]=0x190.
   - Expect resp_valid held through 5 cycles of resp_ready=0.
3. **Stale ack:** status[3]=1 at accept of req_cmd=0x01.
   - Expect a 0x08 strobe first, a wait for ack low, then a 0x01 strobe.
4. **Fire-and-forget:** req_cmd=0x08.
   - Expect a single strobe, no clear strobe, resp_rdata=0, resp_valid at A+2.
5. **Timeout (LCHUB_TIMEOUT_EN, TIMEOUT_CYCLES=16):** req_cmd=0x05 with ack never raised.
   - Expect resp_timeout=1 and resp_rdata=0.
   - Expect no clear strobe.
   - Next request performs normally.
6. **Reset mid-operation:** reset_n low during WAIT_ACK.
   - Expect command_strobe=0, regIn=0, busy=0 immediately.
   - Expect req_ready=1 after release.
